// File: rtl/spi_reg_burst.sv
// SPI mode-0 slave register bridge: cmd bit, address, then a burst of data words.
// Optional macro SPI_REG_BURST_SYNC_EN adds 2-flop input synchronizers.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   ena             block enable (0 forces IDLE)
//   spi_cs_n        SPI chip select, active-low
//   spi_clk         SPI clock (mode 0)
//   spi_mosi        SPI data in, MSB first
//   spi_miso        SPI data out, MSB first
//   reg_addr        current register address
//   reg_data_i      peripheral read data (valid 1 cycle after reg_rd_stb)
//   reg_data_o      peripheral write data
//   reg_data_o_dv   one-cycle write strobe
//   reg_rd_stb      one-cycle read request
//   busy            frame in progress
module spi_reg_burst #(
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 8,
    parameter int AUTO_INC = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic              spi_cs_n,
    input  logic              spi_clk,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic [ADDR_W-1:0] reg_addr,
    input  logic [DATA_W-1:0] reg_data_i,
    output logic [DATA_W-1:0] reg_data_o,
    output logic              reg_data_o_dv,
    output logic              reg_rd_stb,
    output logic              busy
);

    localparam int SH_W  = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int CNT_W = $clog2(SH_W) + 1;
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [2:0] {IDLE, CMD, ADDR, WDATA, RDATA} state_t;

    logic cs_s, sck_s, mosi_s;

`ifdef SPI_REG_BURST_SYNC_EN
    logic [1:0] cs_sync_q, sck_sync_q, mosi_sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cs_sync_q   <= '0;
            sck_sync_q  <= '0;
            mosi_sync_q <= '0;
        end else begin
            cs_sync_q   <= {cs_sync_q[0], spi_cs_n};
            sck_sync_q  <= {sck_sync_q[0], spi_clk};
            mosi_sync_q <= {mosi_sync_q[0], spi_mosi};
        end
    end

    assign cs_s   = cs_sync_q[1];
    assign sck_s  = sck_sync_q[1];
    assign mosi_s = mosi_sync_q[1];
`else
    assign cs_s   = spi_cs_n;
    assign sck_s  = spi_clk;
    assign mosi_s = spi_mosi;
`endif

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SH_W-1:0]   shift_q, shift_d;
    logic              cmd_q, cmd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_o_q, data_o_d;
    logic              dv_q, dv_d;
    logic              rd_stb_q, rd_stb_d;
    logic              ld_q, ld_d;
    logic              sck_prev_q, cs_prev_q;

    logic              sck_rise, sck_fall, cs_fall;
    logic [SH_W-1:0]   sh_next;
    logic [CNT_W-1:0]  cnt_inc;

    // Prev-state flops reset low so a CS held low through reset
    // never looks like a fresh frame start.
    assign sck_rise = sck_s & ~sck_prev_q;
    assign sck_fall = ~sck_s & sck_prev_q;
    assign cs_fall  = ~cs_s & cs_prev_q;
    assign sh_next  = {shift_q[SH_W-2:0], mosi_s};
    assign cnt_inc  = cnt_q + CNT_W'(1);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        cmd_d    = cmd_q;
        addr_d   = addr_q;
        data_o_d = data_o_q;
        dv_d     = 1'b0;
        rd_stb_d = 1'b0;
        ld_d     = rd_stb_q;

        // Address steps the cycle after a write strobe.
        if (dv_q && AUTO_INC != 0) addr_d = addr_q + ADDR_W'(1);
        // Read data lands one cycle after the request.
        if (ld_q) shift_d[DATA_W-1:0] = reg_data_i;

        unique case (state_q)
            IDLE: begin
                if (ena && cs_fall) begin
                    state_d = CMD;
                    cnt_d   = '0;
                end
            end
            CMD: begin
                if (sck_rise) begin
                    cmd_d   = mosi_s;
                    state_d = ADDR;
                    cnt_d   = '0;
                end
            end
            ADDR: begin
                if (sck_rise) begin
                    shift_d = sh_next;
                    cnt_d   = cnt_inc;
                    if (cnt_q == ADDR_LAST) begin
                        addr_d = sh_next[ADDR_W-1:0];
                        cnt_d  = '0;
                        if (cmd_q) begin
                            state_d = WDATA;
                        end else begin
                            state_d  = RDATA;
                            rd_stb_d = 1'b1;
                        end
                    end
                end
            end
            WDATA: begin
                if (sck_rise) begin
                    shift_d = sh_next;
                    cnt_d   = cnt_inc;
                    if (cnt_q == DATA_LAST) begin
                        cnt_d    = '0;
                        data_o_d = sh_next[DATA_W-1:0];
                        dv_d     = 1'b1;
                    end
                end
            end
            RDATA: begin
                // The fall right after a word boundary must not shift:
                // the freshly loaded MSB is still on the wire.
                if (sck_fall && cnt_q != '0)
                    shift_d = {shift_q[SH_W-2:0], 1'b0};
                if (sck_rise) begin
                    cnt_d = cnt_inc;
                    if (cnt_q == DATA_LAST) begin
                        cnt_d    = '0;
                        rd_stb_d = 1'b1;
                        if (AUTO_INC != 0) addr_d = addr_q + ADDR_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort after edge processing so a completing edge still strobes.
        if (state_q != IDLE && (cs_s || !ena)) state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            shift_q    <= '0;
            cmd_q      <= 1'b0;
            addr_q     <= '0;
            data_o_q   <= '0;
            dv_q       <= 1'b0;
            rd_stb_q   <= 1'b0;
            ld_q       <= 1'b0;
            sck_prev_q <= 1'b0;
            cs_prev_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            cmd_q      <= cmd_d;
            addr_q     <= addr_d;
            data_o_q   <= data_o_d;
            dv_q       <= dv_d;
            rd_stb_q   <= rd_stb_d;
            ld_q       <= ld_d;
            sck_prev_q <= sck_s;
            cs_prev_q  <= cs_s;
        end
    end

    assign busy          = (state_q != IDLE);
    assign spi_miso      = (state_q == RDATA) & shift_q[DATA_W-1];
    assign reg_addr      = addr_q;
    assign reg_data_o    = data_o_q;
    assign reg_data_o_dv = dv_q;
    assign reg_rd_stb    = rd_stb_q;

endmodule

// File: tb/tb_spi_reg_burst.sv
// Bench for spi_reg_burst: directed and random SPI frames
// checked against a frame-level model of writes and reads.
module tb_spi_reg_burst;

    localparam int PH = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ena = 1'b1;
    logic sclk = 1'b0;
    logic mosi = 1'b0;
    logic cs0_n = 1'b1;
    logic cs1_n = 1'b1;

    logic       miso0, dv0, rd_stb0, busy0;
    logic [3:0] addr0;
    logic [7:0] wdata0;
    logic [7:0] rdata0 = '0;

    logic        miso1, dv1, rd_stb1, busy1;
    logic [5:0]  addr1;
    logic [31:0] wdata1;
    logic [31:0] rdata1 = '0;

    always #5 clk = ~clk;

    spi_reg_burst #(.ADDR_W(4), .DATA_W(8), .AUTO_INC(1)) dut0 (
        .clk(clk), .rst(rst), .ena(ena),
        .spi_cs_n(cs0_n), .spi_clk(sclk), .spi_mosi(mosi),
        .spi_miso(miso0), .reg_addr(addr0),
        .reg_data_i(rdata0), .reg_data_o(wdata0),
        .reg_data_o_dv(dv0), .reg_rd_stb(rd_stb0), .busy(busy0)
    );

    spi_reg_burst #(.ADDR_W(6), .DATA_W(32), .AUTO_INC(0)) dut1 (
        .clk(clk), .rst(rst), .ena(ena),
        .spi_cs_n(cs1_n), .spi_clk(sclk), .spi_mosi(mosi),
        .spi_miso(miso1), .reg_addr(addr1),
        .reg_data_i(rdata1), .reg_data_o(wdata1),
        .reg_data_o_dv(dv1), .reg_rd_stb(rd_stb1), .busy(busy1)
    );

    // Peripheral model: register file with 1-cycle read latency.
    logic [7:0] mem [16];
    always @(posedge clk) if (rd_stb0) rdata0 <= mem[addr0];

    // Observed strobes.
    logic [3:0]  wa0_q [$];
    logic [7:0]  wd0_q [$];
    logic [5:0]  wa1_q [$];
    logic [31:0] wd1_q [$];
    int rdcnt0 = 0;

    always @(negedge clk) begin
        if (dv0) begin
            wa0_q.push_back(addr0);
            wd0_q.push_back(wdata0);
        end
        if (dv1) begin
            wa1_q.push_back(addr1);
            wd1_q.push_back(wdata1);
        end
        if (rd_stb0) rdcnt0++;
    end

    int n_checks = 0;
    int n_pass = 0;
    int sel = 0;
    logic [31:0] tx [8];
    logic [31:0] rx [8];

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic xfer(input logic [31:0] v, input int n,
                        output logic [31:0] got);
        got = '0;
        for (int i = n - 1; i >= 0; i--) begin
            mosi = v[i];
            tick(PH);
            got = {got[30:0], (sel != 0) ? miso1 : miso0};
            sclk = 1'b1;
            tick(PH);
            sclk = 1'b0;
        end
    endtask

    task automatic cs_set(input logic v);
        if (sel != 0) cs1_n = v;
        else cs0_n = v;
    endtask

    // Full frame; abort_bits > 0 appends that many bits of tx[nw] then ends.
    task automatic frame(input bit cmd, input int addr, input int nw,
                         input int abort_bits);
        logic [31:0] g;
        int aw, dw;
        aw = (sel != 0) ? 6 : 4;
        dw = (sel != 0) ? 32 : 8;
        cs_set(1'b0);
        tick(PH);
        xfer(32'(cmd), 1, g);
        xfer(32'(addr), aw, g);
        for (int k = 0; k < nw; k++) begin
            xfer(tx[k], dw, g);
            rx[k] = g;
        end
        if (abort_bits > 0) xfer(tx[nw] >> (dw - abort_bits), abort_bits, g);
        tick(PH);
        cs_set(1'b1);
        tick(2 * PH);
    endtask

    task automatic clear_obs();
        wa0_q.delete();
        wd0_q.delete();
        wa1_q.delete();
        wd1_q.delete();
    endtask

    initial begin
        int a, nw, r0;
        bit cmd;
        logic [31:0] g;

        for (int i = 0; i < 16; i++) mem[i] = 8'(i * 16);

        // Reset state.
        tick(3);
        check("rst_miso", 64'(miso0), 64'd0);
        check("rst_addr", 64'(addr0), 64'd0);
        check("rst_wdata", 64'(wdata0), 64'd0);
        check("rst_dv", 64'(dv0), 64'd0);
        check("rst_rdstb", 64'(rd_stb0), 64'd0);
        check("rst_busy", 64'(busy0), 64'd0);
        rst = 1'b0;
        tick(4);

        // Single write 0x5 <- 0xA3, busy seen mid-frame.
        sel = 0;
        clear_obs();
        cs0_n = 1'b0;
        tick(PH);
        check("busy_mid", 64'(busy0), 64'd1);
        xfer(32'd1, 1, g);
        xfer(32'h5, 4, g);
        xfer(32'hA3, 8, g);
        tick(PH);
        cs0_n = 1'b1;
        tick(2 * PH);
        check("wr1_cnt", 64'(wa0_q.size()), 64'd1);
        if (wa0_q.size() == 1) begin
            check("wr1_addr", 64'(wa0_q[0]), 64'h5);
            check("wr1_data", 64'(wd0_q[0]), 64'hA3);
        end
        check("wr1_busy", 64'(busy0), 64'd0);

        // Burst write with wrap.
        clear_obs();
        tx[0] = 32'h11; tx[1] = 32'h22; tx[2] = 32'h33;
        frame(1'b1, 'hE, 3, 0);
        check("bw_cnt", 64'(wa0_q.size()), 64'd3);
        for (int k = 0; k < 3 && k < wa0_q.size(); k++) begin
            check("bw_addr", 64'(wa0_q[k]), 64'((14 + k) % 16));
            check("bw_data", 64'(wd0_q[k]), 64'(tx[k][7:0]));
        end

        // Burst read 2 words from 0x2.
        r0 = rdcnt0;
        frame(1'b0, 'h2, 2, 0);
        check("rd_w0", 64'(rx[0][7:0]), 64'h20);
        check("rd_w1", 64'(rx[1][7:0]), 64'h30);
        check("rd_stb_cnt", 64'(rdcnt0 - r0), 64'd3);
        check("rd_miso_idle", 64'(miso0), 64'd0);

        // Aborted write, then a good one.
        clear_obs();
        tx[0] = 32'hFF;
        frame(1'b1, 'h9, 0, 5);
        check("ab_nodv", 64'(wa0_q.size()), 64'd0);
        check("ab_busy", 64'(busy0), 64'd0);
        tx[0] = 32'h5A;
        frame(1'b1, 'h7, 1, 0);
        check("ab2_cnt", 64'(wa0_q.size()), 64'd1);
        if (wa0_q.size() == 1) begin
            check("ab2_addr", 64'(wa0_q[0]), 64'h7);
            check("ab2_data", 64'(wd0_q[0]), 64'h5A);
        end

        // Reset during the address phase.
        clear_obs();
        cs0_n = 1'b0;
        tick(PH);
        xfer(32'd1, 1, g);
        xfer(32'h2, 2, g);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("rm_addr", 64'(addr0), 64'd0);
        check("rm_wdata", 64'(wdata0), 64'd0);
        check("rm_busy", 64'(busy0), 64'd0);
        tick(2);
        check("rm_busy2", 64'(busy0), 64'd0);
        cs0_n = 1'b1;
        tick(2 * PH);
        tx[0] = 32'hC4;
        frame(1'b1, 'hB, 1, 0);
        check("rm_cnt", 64'(wa0_q.size()), 64'd1);
        if (wa0_q.size() == 1) begin
            check("rm_waddr", 64'(wa0_q[0]), 64'hB);
            check("rm_wd", 64'(wd0_q[0]), 64'hC4);
        end

        // Random frames against the frame-level model.
        for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
        for (int f = 0; f < 10; f++) begin
            cmd = 1'($urandom_range(0, 1));
            a = $urandom_range(0, 15);
            nw = $urandom_range(1, 4);
            for (int k = 0; k < nw; k++) tx[k] = 32'($urandom_range(0, 255));
            clear_obs();
            r0 = rdcnt0;
            frame(cmd, a, nw, 0);
            if (cmd) begin
                check("rw_cnt", 64'(wa0_q.size()), 64'(nw));
                for (int k = 0; k < nw && k < wa0_q.size(); k++) begin
                    check("rw_addr", 64'(wa0_q[k]), 64'((a + k) % 16));
                    check("rw_data", 64'(wd0_q[k]), 64'(tx[k][7:0]));
                end
                for (int k = 0; k < nw; k++) mem[(a + k) % 16] = tx[k][7:0];
            end else begin
                for (int k = 0; k < nw; k++)
                    check("rr_data", 64'(rx[k][7:0]), 64'(mem[(a + k) % 16]));
                check("rr_stb", 64'(rdcnt0 - r0), 64'(nw + 1));
            end
        end

        // Wide instance: 32-bit data, 6-bit address, no auto-increment.
        sel = 1;
        clear_obs();
        tx[0] = 32'hDEADBEEF;
        frame(1'b1, 'h3F, 1, 0);
        check("w32_cnt", 64'(wa1_q.size()), 64'd1);
        if (wa1_q.size() == 1) begin
            check("w32_addr", 64'(wa1_q[0]), 64'h3F);
            check("w32_data", 64'(wd1_q[0]), 64'hDEADBEEF);
        end
        clear_obs();
        tx[0] = $urandom; tx[1] = $urandom; tx[2] = $urandom;
        frame(1'b1, 'h15, 3, 0);
        check("ni_cnt", 64'(wa1_q.size()), 64'd3);
        for (int k = 0; k < 3 && k < wa1_q.size(); k++) begin
            check("ni_addr", 64'(wa1_q[k]), 64'h15);
            check("ni_data", 64'(wd1_q[k]), 64'(tx[k]));
        end
        check("ni_busy", 64'(busy1), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
